// File: rtl/reservation_station_pkg.sv
// -----------------------------------------------------------------------------
// reservation_station_pkg
// Shared widths, opcode constants and record types for the reservation station.
// No ports: imported by the interface, the picker and the top level.
// -----------------------------------------------------------------------------
package reservation_station_pkg;

    localparam int DATA_W     = 32;
    localparam int PC_W       = 32;
    localparam int OP_W       = 4;
    localparam int RS_ENTRIES = 8;
    localparam int IDX_W      = $clog2(RS_ENTRIES);
    localparam int CNT_W      = 4;   // must hold 0..RS_ENTRIES inclusive

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [OP_W-1:0]   op_t;

    // A producer tag of zero means the operand value is already present.
    localparam pc_t TAG_READY = '0;

    localparam op_t OP_NOP = 4'h0;
    localparam op_t OP_ADD = 4'h1;
    localparam op_t OP_SUB = 4'h2;
    localparam op_t OP_AND = 4'h3;
    localparam op_t OP_OR  = 4'h4;
    localparam op_t OP_XOR = 4'h5;
    localparam op_t OP_SLL = 4'h6;
    localparam op_t OP_SRL = 4'h7;

    // One reservation-station slot.
    typedef struct packed {
        logic  valid;
        op_t   op;
        data_t v1;
        data_t v2;
        pc_t   q1;
        pc_t   q2;
        data_t imm;
        pc_t   pc;
    } rs_entry_t;

    // Registered dispatch packet toward the ALU.
    typedef struct packed {
        logic  valid;
        op_t   op;
        data_t v1;
        data_t v2;
        data_t imm;
        pc_t   pc;
    } alu_pkt_t;

    // Number of set bits in a slot-valid vector.
    function automatic logic [CNT_W-1:0] count_valid(input logic [RS_ENTRIES-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// -----------------------------------------------------------------------------
// reservation_station_if
// Bundles the ROB issue/commit channel and the ALU dispatch channel.
//   master : ROB/ALU side  - drives issue, commit and flush; sees stall, count
//            and the dispatch packet.
//   slave  : reservation station - the reverse directions.
// -----------------------------------------------------------------------------
interface reservation_station_if;
    import reservation_station_pkg::*;

    // Issue / flush from the ROB
    logic  is_exception_from_rob;
    logic  is_empty_from_rob;
    logic  is_sl_from_rob;
    op_t   op_from_rob;
    pc_t   pc_from_rob;
    data_t v1_from_rob;
    data_t v2_from_rob;
    data_t imm_from_rob;
    pc_t   q1_from_rob;
    pc_t   q2_from_rob;

    // Result broadcast
    logic  commit_valid_from_rob;
    pc_t   commit_pc_from_rob;
    data_t commit_data_from_rob;

    // Back-pressure and occupancy to the ROB
    logic             is_stall_to_rob;
    logic [CNT_W-1:0] count_to_rob;

    // Dispatch packet to the ALU
    logic  is_valid_to_alu;
    op_t   op_to_alu;
    data_t v1_to_alu;
    data_t v2_to_alu;
    data_t imm_to_alu;
    pc_t   pc_to_alu;

    modport master (
        output is_exception_from_rob, is_empty_from_rob, is_sl_from_rob,
               op_from_rob, pc_from_rob, v1_from_rob, v2_from_rob, imm_from_rob,
               q1_from_rob, q2_from_rob,
               commit_valid_from_rob, commit_pc_from_rob, commit_data_from_rob,
        input  is_stall_to_rob, count_to_rob,
               is_valid_to_alu, op_to_alu, v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu
    );

    modport slave (
        input  is_exception_from_rob, is_empty_from_rob, is_sl_from_rob,
               op_from_rob, pc_from_rob, v1_from_rob, v2_from_rob, imm_from_rob,
               q1_from_rob, q2_from_rob,
               commit_valid_from_rob, commit_pc_from_rob, commit_data_from_rob,
        output is_stall_to_rob, count_to_rob,
               is_valid_to_alu, op_to_alu, v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu
    );

endinterface

// File: rtl/reservation_station_rs_pick.sv
// -----------------------------------------------------------------------------
// rs_pick
// Lowest-index priority picker over the slot vector. Used both to find the
// first free slot for issue and the first ready slot for dispatch.
//   req   : one request bit per slot
//   idx   : index of the lowest set bit (0 when none)
//   found : at least one bit of req is set
// -----------------------------------------------------------------------------
module rs_pick
    import reservation_station_pkg::*;
(
    input  logic [RS_ENTRIES-1:0] req,
    output logic [IDX_W-1:0]      idx,
    output logic                  found
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Scan downward so the last hit written is the lowest index.
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// -----------------------------------------------------------------------------
// reservation_station
// Eight-slot reservation station between the ROB and a single ALU. Accepts at
// most one issue and performs at most one dispatch per cycle; waiting operands
// are filled from the commit broadcast, including same-edge bypass on issue.
//   clk   : clock, all state on the rising edge
//   rst   : asynchronous active-high reset
//   rs_if : slave side of reservation_station_if (issue, commit, flush,
//           stall/count back to the ROB, registered dispatch packet)
// -----------------------------------------------------------------------------
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    reservation_station_if.slave rs_if
);

    rs_entry_t [RS_ENTRIES-1:0] ent_q, ent_d;
    alu_pkt_t                   alu_q, alu_d;

    logic [RS_ENTRIES-1:0] valid_vec;
    logic [RS_ENTRIES-1:0] ready_vec;
    logic [IDX_W-1:0]      free_idx, rdy_idx;
    logic                  free_found, rdy_found;
    logic                  commit_hit;
    logic                  issue_ok;
    rs_entry_t             new_entry;

    // Slot status, all from pre-edge state.
    always_comb begin
        valid_vec = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            valid_vec[i] = ent_q[i].valid;
            ready_vec[i] = ent_q[i].valid && (ent_q[i].q1 == TAG_READY)
                                          && (ent_q[i].q2 == TAG_READY);
        end
    end

    rs_pick u_pick_free (
        .req   (~valid_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_pick u_pick_ready (
        .req   (ready_vec),
        .idx   (rdy_idx),
        .found (rdy_found)
    );

    // A zero commit tag would otherwise match every ready operand.
    assign commit_hit = rs_if.commit_valid_from_rob
                     && (rs_if.commit_pc_from_rob != TAG_READY);

    // free_found is low exactly when the station is full.
    assign issue_ok = !rs_if.is_empty_from_rob && !rs_if.is_sl_from_rob && free_found;

    // Incoming packet with same-edge bypass from the commit broadcast.
    always_comb begin
        new_entry       = '0;
        new_entry.valid = 1'b1;
        new_entry.op    = rs_if.op_from_rob;
        new_entry.v1    = rs_if.v1_from_rob;
        new_entry.v2    = rs_if.v2_from_rob;
        new_entry.q1    = rs_if.q1_from_rob;
        new_entry.q2    = rs_if.q2_from_rob;
        new_entry.imm   = rs_if.imm_from_rob;
        new_entry.pc    = rs_if.pc_from_rob;
        if (commit_hit && (rs_if.q1_from_rob == rs_if.commit_pc_from_rob)) begin
            new_entry.v1 = rs_if.commit_data_from_rob;
            new_entry.q1 = TAG_READY;
        end
        if (commit_hit && (rs_if.q2_from_rob == rs_if.commit_pc_from_rob)) begin
            new_entry.v2 = rs_if.commit_data_from_rob;
            new_entry.q2 = TAG_READY;
        end
    end

    // Next-state: flush beats everything; otherwise wakeup, dispatch, issue.
    // Dispatch only touches a ready slot (tags zero, so never woken this edge)
    // and issue only touches a free slot, so the three never collide.
    always_comb begin
        ent_d       = ent_q;
        alu_d       = alu_q;          // data outputs hold when nothing dispatches
        alu_d.valid = 1'b0;

        if (rs_if.is_exception_from_rob) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                ent_d[i].valid = 1'b0;
            end
        end else begin
            if (commit_hit) begin
                for (int i = 0; i < RS_ENTRIES; i++) begin
                    if (ent_q[i].valid && (ent_q[i].q1 == rs_if.commit_pc_from_rob)) begin
                        ent_d[i].v1 = rs_if.commit_data_from_rob;
                        ent_d[i].q1 = TAG_READY;
                    end
                    if (ent_q[i].valid && (ent_q[i].q2 == rs_if.commit_pc_from_rob)) begin
                        ent_d[i].v2 = rs_if.commit_data_from_rob;
                        ent_d[i].q2 = TAG_READY;
                    end
                end
            end

            if (rdy_found) begin
                alu_d.valid            = 1'b1;
                alu_d.op               = ent_q[rdy_idx].op;
                alu_d.v1               = ent_q[rdy_idx].v1;
                alu_d.v2               = ent_q[rdy_idx].v2;
                alu_d.imm              = ent_q[rdy_idx].imm;
                alu_d.pc               = ent_q[rdy_idx].pc;
                ent_d[rdy_idx].valid   = 1'b0;
            end

            if (issue_ok) begin
                ent_d[free_idx] = new_entry;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering in simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the slot storage is reset in full, not just the valid bits,
            // so that no stale operand or tag survives into the next run.
            ent_q <= '0;
            alu_q <= '0;
        end else begin
            ent_q <= ent_d;
            alu_q <= alu_d;
        end
    end

    assign rs_if.is_stall_to_rob = &valid_vec;
    assign rs_if.count_to_rob    = count_valid(valid_vec);

    assign rs_if.is_valid_to_alu = alu_q.valid;
    assign rs_if.op_to_alu       = alu_q.op;
    assign rs_if.v1_to_alu       = alu_q.v1;
    assign rs_if.v2_to_alu       = alu_q.v2;
    assign rs_if.imm_to_alu      = alu_q.imm;
    assign rs_if.pc_to_alu       = alu_q.pc;

endmodule

// File: tb/tb_reservation_station.sv
// -----------------------------------------------------------------------------
// tb_reservation_station
// Directed stimulus for the reservation station. Inputs change on the falling
// edge; the stimulus thread queues each packet it expects the ALU to receive
// and a separate monitor pops and compares on every falling edge where
// is_valid_to_alu is high.
// -----------------------------------------------------------------------------
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    alu_pkt_t exp_q[$];

    reservation_station_if bus();

    reservation_station dut (
        .clk   (clk),
        .rst   (rst),
        .rs_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.is_exception_from_rob = 1'b0;
        bus.is_empty_from_rob     = 1'b1;
        bus.is_sl_from_rob        = 1'b0;
        bus.op_from_rob           = OP_NOP;
        bus.pc_from_rob           = '0;
        bus.v1_from_rob           = '0;
        bus.v2_from_rob           = '0;
        bus.imm_from_rob          = '0;
        bus.q1_from_rob           = '0;
        bus.q2_from_rob           = '0;
        bus.commit_valid_from_rob = 1'b0;
        bus.commit_pc_from_rob    = '0;
        bus.commit_data_from_rob  = '0;
    endtask

    task automatic set_issue(input op_t op, input data_t v1, input data_t v2,
                             input pc_t q1, input pc_t q2, input data_t imm, input pc_t pc);
        bus.is_empty_from_rob = 1'b0;
        bus.op_from_rob       = op;
        bus.v1_from_rob       = v1;
        bus.v2_from_rob       = v2;
        bus.q1_from_rob       = q1;
        bus.q2_from_rob       = q2;
        bus.imm_from_rob      = imm;
        bus.pc_from_rob       = pc;
    endtask

    task automatic set_commit(input pc_t pc, input data_t data);
        bus.commit_valid_from_rob = 1'b1;
        bus.commit_pc_from_rob    = pc;
        bus.commit_data_from_rob  = data;
    endtask

    task automatic push_exp(input op_t op, input data_t v1, input data_t v2,
                            input data_t imm, input pc_t pc);
        alu_pkt_t p;
        p.valid = 1'b1;
        p.op    = op;
        p.v1    = v1;
        p.v2    = v2;
        p.imm   = imm;
        p.pc    = pc;
        exp_q.push_back(p);
    endtask

    // One rising edge with the currently driven inputs, then back to idle.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst && bus.is_valid_to_alu) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dispatch: got pc 0x%08h expected no dispatch at %0t",
                         bus.pc_to_alu, $time);
            end else begin
                alu_pkt_t e;
                e = exp_q.pop_front();
                check("dispatch_op",  32'(bus.op_to_alu), 32'(e.op));
                check("dispatch_v1",  bus.v1_to_alu,  e.v1);
                check("dispatch_v2",  bus.v2_to_alu,  e.v2);
                check("dispatch_imm", bus.imm_to_alu, e.imm);
                check("dispatch_pc",  bus.pc_to_alu,  e.pc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        #3;
        // Reset state
        check("reset_stall", 32'(bus.is_stall_to_rob), 32'd0);
        check("reset_count", 32'(bus.count_to_rob),    32'd0);
        check("reset_valid", 32'(bus.is_valid_to_alu), 32'd0);
        check("reset_pc",    bus.pc_to_alu,             32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Ready packet: issue at one edge, dispatch at the next.
        set_issue(OP_ADD, 32'd5, 32'd7, 32'h0, 32'h0, 32'd3, 32'h10);
        push_exp(OP_ADD, 32'd5, 32'd7, 32'd3, 32'h10);
        cycle();
        check("t1_count_after_issue", 32'(bus.count_to_rob), 32'd1);
        cycle();
        check("t1_count_after_dispatch", 32'(bus.count_to_rob), 32'd0);

        // Wakeup of v1 two cycles after issue.
        set_issue(OP_SUB, 32'hFFFF, 32'd1, 32'h100, 32'h0, 32'd4, 32'h20);
        cycle();
        cycle();
        set_commit(32'h100, 32'h2A);
        push_exp(OP_SUB, 32'h2A, 32'd1, 32'd4, 32'h20);
        cycle();
        check("t2_count_after_wakeup", 32'(bus.count_to_rob), 32'd1);
        cycle();
        check("t2_count_after_dispatch", 32'(bus.count_to_rob), 32'd0);

        // Same-edge bypass on v2.
        set_issue(OP_AND, 32'd4, 32'hDEAD, 32'h0, 32'h200, 32'd0, 32'h30);
        set_commit(32'h200, 32'd9);
        push_exp(OP_AND, 32'd4, 32'd9, 32'd0, 32'h30);
        cycle();
        check("t3_count_after_issue", 32'(bus.count_to_rob), 32'd1);
        cycle();
        check("t3_count_after_dispatch", 32'(bus.count_to_rob), 32'd0);

        // Fill all eight slots with dependent packets.
        for (int i = 0; i < 8; i++) begin
            set_issue(OP_OR, 32'(i), 32'h10 + 32'(i), 32'h300 + 32'(i), 32'h0,
                      32'h1000 + 32'(i), 32'h40 + 32'(i));
            cycle();
        end
        check("t4_stall_full", 32'(bus.is_stall_to_rob), 32'd1);
        check("t4_count_full", 32'(bus.count_to_rob),    32'd8);
        // Ninth (ready) packet must be dropped.
        set_issue(OP_XOR, 32'd1, 32'd2, 32'h0, 32'h0, 32'd0, 32'h99);
        cycle();
        check("t4_count_ninth_refused", 32'(bus.count_to_rob), 32'd8);
        // Commit tag zero changes nothing.
        set_commit(32'h0, 32'hDEAD);
        cycle();
        check("t4_count_tag0", 32'(bus.count_to_rob), 32'd8);
        // Wake slot 3.
        set_commit(32'h303, 32'h77);
        push_exp(OP_OR, 32'h77, 32'h13, 32'h1003, 32'h43);
        cycle();
        check("t4_stall_after_wakeup", 32'(bus.is_stall_to_rob), 32'd1);
        // Issue while full on the dispatch edge: refused, dispatch proceeds.
        set_issue(OP_XOR, 32'd1, 32'd2, 32'h0, 32'h0, 32'd0, 32'h88);
        cycle();
        check("t4_count_after_dispatch", 32'(bus.count_to_rob),    32'd7);
        check("t4_stall_dropped",        32'(bus.is_stall_to_rob), 32'd0);
        cycle();
        check("t4_count_stable", 32'(bus.count_to_rob), 32'd7);
        // Flush the remainder.
        bus.is_exception_from_rob = 1'b1;
        cycle();
        check("t4_count_flushed", 32'(bus.count_to_rob), 32'd0);

        // Five slots, the last one ready, then a flush with issue and commit.
        for (int i = 0; i < 4; i++) begin
            set_issue(OP_SLL, 32'(i), 32'd1, 32'h500 + 32'(i), 32'h0, 32'd0, 32'h50 + 32'(i));
            cycle();
        end
        set_issue(OP_SRL, 32'd8, 32'd1, 32'h0, 32'h0, 32'd0, 32'h55);
        cycle();
        check("t5_count_five", 32'(bus.count_to_rob), 32'd5);
        bus.is_exception_from_rob = 1'b1;
        set_commit(32'h500, 32'h1);
        set_issue(OP_ADD, 32'd1, 32'd1, 32'h0, 32'h0, 32'd0, 32'h5F);
        cycle();
        check("t5_count_flushed", 32'(bus.count_to_rob),    32'd0);
        check("t5_no_dispatch",   32'(bus.is_valid_to_alu), 32'd0);
        // Two packets on one tag: dispatch order shows slot allocation from 0.
        set_issue(OP_ADD, 32'd0, 32'd2, 32'h600, 32'h0, 32'd0, 32'h60);
        cycle();
        set_issue(OP_SUB, 32'd0, 32'd3, 32'h600, 32'h0, 32'd0, 32'h61);
        cycle();
        set_commit(32'h600, 32'h11);
        push_exp(OP_ADD, 32'h11, 32'd2, 32'd0, 32'h60);
        push_exp(OP_SUB, 32'h11, 32'd3, 32'd0, 32'h61);
        cycle();
        check("t5_count_two", 32'(bus.count_to_rob), 32'd2);
        cycle();
        check("t5_count_one", 32'(bus.count_to_rob), 32'd1);
        cycle();
        check("t5_count_zero", 32'(bus.count_to_rob), 32'd0);

        // Load/store and empty-marked packets never occupy a slot.
        set_issue(OP_ADD, 32'd1, 32'd1, 32'h0, 32'h0, 32'd0, 32'h70);
        bus.is_sl_from_rob = 1'b1;
        cycle();
        check("t6_sl_ignored", 32'(bus.count_to_rob), 32'd0);
        set_issue(OP_ADD, 32'd1, 32'd1, 32'h0, 32'h0, 32'd0, 32'h71);
        bus.is_empty_from_rob = 1'b1;
        cycle();
        check("t6_empty_ignored", 32'(bus.count_to_rob), 32'd0);
        cycle();

        // Asynchronous reset while a dispatch is on the outputs.
        set_issue(OP_XOR, 32'd0, 32'd0, 32'h700, 32'h0, 32'd0, 32'h80);
        cycle();
        set_issue(OP_XOR, 32'hA5, 32'h5A, 32'h0, 32'h0, 32'd6, 32'h81);
        push_exp(OP_XOR, 32'hA5, 32'h5A, 32'd6, 32'h81);
        cycle();
        cycle();
        check("t7_count_before_rst", 32'(bus.count_to_rob), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t7_rst_valid", 32'(bus.is_valid_to_alu), 32'd0);
        check("t7_rst_v1",    bus.v1_to_alu,             32'd0);
        check("t7_rst_pc",    bus.pc_to_alu,             32'd0);
        check("t7_rst_count", 32'(bus.count_to_rob),     32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        // The discarded dependent packet must not wake; new issue accepted at once.
        set_issue(OP_AND, 32'd3, 32'd4, 32'h0, 32'h0, 32'd0, 32'h90);
        set_commit(32'h700, 32'h5);
        push_exp(OP_AND, 32'd3, 32'd4, 32'd0, 32'h90);
        cycle();
        check("t7_first_accept", 32'(bus.count_to_rob), 32'd1);
        cycle();
        check("t7_count_drained", 32'(bus.count_to_rob), 32'd0);
        cycle();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 is_exception_from_rob  in  1  synchronous flush request.
REQ-004 is_empty_from_rob  in  1  low = issue packet valid this cycle.
REQ-005 is_sl_from_rob  in  1  high = packet belongs to load/store buffer, RS ignores.
REQ-006 op_from_rob  in  OP_W  opcode; pc_from_rob  in  32  instruction tag.
REQ-007 v1_from_rob, v2_from_rob, imm_from_rob  in  32 each  operand values, immediate.
REQ-008 q1_from_rob, q2_from_rob  in  32 each  producer tag; 0 = operand ready.
REQ-009 commit_valid_from_rob  in  1; commit_pc_from_rob  in  32; commit_data_from_rob  in  32  result broadcast.
REQ-010 is_stall_to_rob  out  1  RS full; ROB holds issue.
REQ-011 is_valid_to_alu  out  1; op_to_alu OP_W; v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu  out  32  dispatch packet.
REQ-012 count_to_rob  out  4  occupied entries, 0..8.

Function
REQ-013 Storage SHALL be 8 entries: valid, op, v1, v2, q1, q2, imm, pc.
REQ-014 Issue SHALL be accepted at an edge iff is_empty_from_rob=0, is_sl_from_rob=0, not full, no exception; written to lowest-index free entry.
REQ-015 is_stall_to_rob SHALL be combinational: 1 iff all 8 entries valid (pre-edge state).
REQ-016 An issue presented while full SHALL be ignored with no state change.
REQ-017 On commit_valid=1 with commit_pc!=0, every valid entry with q1==commit_pc SHALL load v1<=commit_data, q1<=0; likewise q2/v2.
REQ-018 Commit tag 0 SHALL be ignored.
REQ-019 Same-edge bypass: an issuing packet whose q1/q2 equals commit_pc SHALL be stored with data captured and tag 0.
REQ-020 Entry ready iff valid and q1==0 and q2==0, evaluated on pre-edge state.
REQ-021 Each edge, the lowest-index ready entry SHALL be dispatched: output registers loaded, is_valid_to_alu=1, entry freed; no ready entry -> is_valid_to_alu=0, data outputs hold.
REQ-022 Max one issue and one dispatch per cycle; freed slot reusable from next edge only.
REQ-023 Latency: ready packet issued at edge E dispatches at edge E+1; wakeup at edge W dispatches at W+1 earliest.
REQ-024 Simultaneous issue and dispatch while full: issue refused, dispatch proceeds; stall deasserts after that edge.
REQ-025 count_to_rob SHALL update to reflect issue (+1) and dispatch (-1) of the same edge.
REQ-026 is_exception_from_rob=1 at an edge SHALL clear all valid bits and is_valid_to_alu, ignore issue and commit; highest priority.

Reset
REQ-027 rst=1 SHALL immediately clear all valid bits, all entry fields, all ALU outputs to 0, count_to_rob=0; is_stall_to_rob=0.
REQ-028 Reset mid-operation SHALL discard every entry and in-flight dispatch; first accept on first edge after rst falls.

Structure
REQ-029 Shared package SHALL hold DATA_W=32, PC_W=32, OP_W, RS_ENTRIES=8, TAG_READY=0, opcode constants.
REQ-030 Lowest-index selection SHALL be one sub-module, rs_pick (8-bit request -> 3-bit index + found), used for both free-slot and ready-entry search.

Verification
REQ-031 Issue op ADD, v1=5, v2=7, q1=q2=0 at edge 1 -> edge 2: is_valid_to_alu=1, v1=5, v2=7, count back to 0.
REQ-032 Issue q1=0x100; commit pc=0x100 data=0x2A two cycles later -> dispatch next edge with v1=0x2A.
REQ-033 Issue q2=0x200 in same cycle as commit 0x200 data=9 -> stored ready, dispatched next edge, v2=9.
REQ-034 Issue 8 dependent packets -> is_stall_to_rob=1, count=8; 9th issue ignored; one wakeup -> dispatch, stall drops.
REQ-035 Fill 5 entries, assert is_exception_from_rob one cycle -> count=0, no dispatch, next issue lands in entry 0.
REQ-036 Assert rst mid-dispatch -> outputs zero without clock edge; is_sl_from_rob=1 packet never occupies an entry.
